// File: rtl/chunk_sched_ctrl_pkg.sv
// Shared types and derived widths for the chunk scheduler and its per-operand bank writers.
package chunk_sched_pkg;

  localparam int BUS_SIZE         = 32;
  localparam int MEM_SIZE         = 128;
  localparam int PREFIX_SUM_SIZE  = 8;
  localparam int WR_DAT_CYC_NUM   = MEM_SIZE / BUS_SIZE;
  localparam int RD_SPARSEMAP_NUM = MEM_SIZE / PREFIX_SUM_SIZE;
  localparam int CHUNK_CNT_W      = 16;

  localparam int BEAT_CNT_W  = $clog2(WR_DAT_CYC_NUM);
  localparam int CFG_BEATS_W = BEAT_CNT_W + 1;
  localparam int SPMAP_W     = $clog2(RD_SPARSEMAP_NUM);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/chunk_sched_ctrl_if.sv
// Loader-facing beat handshakes and bank write strobes for the IFM and filter operands.
interface chunk_sched_ctrl_if;

  // A beat transfers on every rising edge where *_beat_valid_i and *_beat_ready_o are both high;
  // valid may not depend on ready, and *_wr_valid_o is exactly that transfer condition.
  logic                                 ifm_beat_valid_i;
  logic                                 ifm_beat_ready_o;
  logic                                 filter_beat_valid_i;
  logic                                 filter_beat_ready_o;
  logic                                 ifm_wr_valid_o;
  logic                                 filter_wr_valid_o;
  logic [chunk_sched_pkg::BEAT_CNT_W-1:0] ifm_wr_count_o;
  logic [chunk_sched_pkg::BEAT_CNT_W-1:0] filter_wr_count_o;
  logic                                 ifm_wr_sel_o;
  logic                                 filter_wr_sel_o;

  modport master (
    output ifm_beat_valid_i, filter_beat_valid_i,
    input  ifm_beat_ready_o, filter_beat_ready_o,
    input  ifm_wr_valid_o, filter_wr_valid_o,
    input  ifm_wr_count_o, filter_wr_count_o,
    input  ifm_wr_sel_o, filter_wr_sel_o
  );

  modport slave (
    input  ifm_beat_valid_i, filter_beat_valid_i,
    output ifm_beat_ready_o, filter_beat_ready_o,
    output ifm_wr_valid_o, filter_wr_valid_o,
    output ifm_wr_count_o, filter_wr_count_o,
    output ifm_wr_sel_o, filter_wr_sel_o
  );

endinterface

// File: rtl/chunk_sched_ctrl_bank.sv
// One operand's ping-pong bank writer: beat counting, write pointer and the two bank-full flags.
module chunk_bank_ctrl
  import chunk_sched_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   busy_i,
  input  logic [CFG_BEATS_W-1:0] beats_i,
  input  logic [CHUNK_CNT_W-1:0] chunk_num_i,
  input  logic                   beat_valid_i,
  output logic                   beat_ready_o,
  output logic                   wr_valid_o,
  output logic [BEAT_CNT_W-1:0]  wr_count_o,
  output logic                   wr_sel_o,
  input  logic                   free_i,
  input  logic                   rd_ptr_i,
  output logic [1:0]             full_o
);

  logic                   wr_ptr;
  logic [BEAT_CNT_W-1:0]  beat_cnt;
  logic [1:0]             full;
  logic [1:0]             full_nxt;
  logic [CHUNK_CNT_W-1:0] chunks_loaded;
  logic                   last_beat;

  // Ready looks only at registered flags, so a bank freed this cycle is writable next cycle.
  assign beat_ready_o = busy_i && !full[wr_ptr] && (chunks_loaded != chunk_num_i);
  assign wr_valid_o   = beat_valid_i && beat_ready_o;
  assign last_beat    = ({1'b0, beat_cnt} == (beats_i - CFG_BEATS_W'(1)));
  assign wr_count_o   = beat_cnt;
  assign wr_sel_o     = wr_ptr;
  assign full_o       = full;

  // The reader frees a full bank while the writer fills an empty one, so both updates can land together.
  always_comb begin
    full_nxt = full;
    if (free_i) full_nxt[rd_ptr_i] = 1'b0;
    if (wr_valid_o && last_beat) full_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      wr_ptr        <= 1'b0;
      beat_cnt      <= '0;
      full          <= 2'b00;
      chunks_loaded <= '0;
    end else begin
      full <= full_nxt;
      if (wr_valid_o) begin
        if (last_beat) begin
          beat_cnt      <= '0;
          wr_ptr        <= ~wr_ptr;
          chunks_loaded <= chunks_loaded + CHUNK_CNT_W'(1);
        end else begin
          beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/chunk_sched_ctrl.sv
// Chunk sequencer: pairs full IFM/filter banks, pulses chunk_start_o, frees banks on chunk_end_i.
// Define CHUNK_SCHED_PERF_EN to add the stall_cyc_o / run_cyc_o cycle counters.
module chunk_sched_ctrl
  import chunk_sched_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [CHUNK_CNT_W-1:0] cfg_chunk_num_i,
  input  logic [CFG_BEATS_W-1:0] cfg_beats_i,
  input  logic [SPMAP_W-1:0]     cfg_sparsemap_num_i,
  chunk_sched_ctrl_if.slave      bus,
  output logic                   ifm_rd_sel_o,
  output logic                   filter_rd_sel_o,
  output logic                   chunk_start_o,
  output logic                   run_valid_o,
  output logic [SPMAP_W-1:0]     rd_sparsemap_num_o,
  input  logic                   chunk_end_i,
  output logic                   busy_o,
  output logic                   done_o,
  output sched_state_e           state_o
`ifdef CHUNK_SCHED_PERF_EN
  ,
  output logic [31:0]            stall_cyc_o,
  output logic [31:0]            run_cyc_o
`endif
);

  sched_state_e           state;
  logic                   rd_ptr;
  logic [CHUNK_CNT_W-1:0] chunks_done;
  logic [CHUNK_CNT_W-1:0] chunk_num_q;
  logic [CFG_BEATS_W-1:0] beats_q;
  logic [1:0]             ifm_full;
  logic [1:0]             filter_full;
  logic                   layer_start;
  logic                   free;
  logic                   both_full;

  assign layer_start     = (state == IDLE) && start_i;
  // START is skipped on purpose: chunk_end_i is only trusted from the first RUN cycle.
  assign free            = (state == RUN) && chunk_end_i;
  assign both_full       = ifm_full[rd_ptr] && filter_full[rd_ptr];
  assign ifm_rd_sel_o    = rd_ptr;
  assign filter_rd_sel_o = rd_ptr;
  assign state_o         = state;

  chunk_bank_ctrl u_ifm_bank (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (layer_start),
    .busy_i       (busy_o),
    .beats_i      (beats_q),
    .chunk_num_i  (chunk_num_q),
    .beat_valid_i (bus.ifm_beat_valid_i),
    .beat_ready_o (bus.ifm_beat_ready_o),
    .wr_valid_o   (bus.ifm_wr_valid_o),
    .wr_count_o   (bus.ifm_wr_count_o),
    .wr_sel_o     (bus.ifm_wr_sel_o),
    .free_i       (free),
    .rd_ptr_i     (rd_ptr),
    .full_o       (ifm_full)
  );

  chunk_bank_ctrl u_filter_bank (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (layer_start),
    .busy_i       (busy_o),
    .beats_i      (beats_q),
    .chunk_num_i  (chunk_num_q),
    .beat_valid_i (bus.filter_beat_valid_i),
    .beat_ready_o (bus.filter_beat_ready_o),
    .wr_valid_o   (bus.filter_wr_valid_o),
    .wr_count_o   (bus.filter_wr_count_o),
    .wr_sel_o     (bus.filter_wr_sel_o),
    .free_i       (free),
    .rd_ptr_i     (rd_ptr),
    .full_o       (filter_full)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state              <= IDLE;
      rd_ptr             <= 1'b0;
      chunks_done        <= '0;
      chunk_num_q        <= '0;
      beats_q            <= '0;
      rd_sparsemap_num_o <= '0;
      chunk_start_o      <= 1'b0;
      run_valid_o        <= 1'b0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
    end else begin
      chunk_start_o <= 1'b0;
      done_o        <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            chunk_num_q        <= cfg_chunk_num_i;
            beats_q            <= cfg_beats_i;
            rd_sparsemap_num_o <= cfg_sparsemap_num_i;
            rd_ptr             <= 1'b0;
            chunks_done        <= '0;
            if (cfg_chunk_num_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state  <= LOAD;
              busy_o <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (both_full) begin
            state         <= START;
            chunk_start_o <= 1'b1;
            run_valid_o   <= 1'b1;
          end
        end
        START: state <= RUN;
        RUN: begin
          if (chunk_end_i) begin
            rd_ptr      <= ~rd_ptr;
            chunks_done <= chunks_done + CHUNK_CNT_W'(1);
            run_valid_o <= 1'b0;
            if ((chunks_done + CHUNK_CNT_W'(1)) == chunk_num_q) begin
              state  <= DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CHUNK_SCHED_PERF_EN
  // Saturating counters; they keep their final values after done until the next accepted start.
  always_ff @(posedge clk_i) begin
    if (!rst_i || layer_start) begin
      stall_cyc_o <= '0;
      run_cyc_o   <= '0;
    end else begin
      if ((state == LOAD) && (stall_cyc_o != '1)) stall_cyc_o <= stall_cyc_o + 32'd1;
      if ((state == RUN) && (run_cyc_o != '1)) run_cyc_o <= run_cyc_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/chunk_sched_ctrl.md
Name: chunk_sched_ctrl

Overview:
- Control-only sequencer for the sparse input-selector datapath.
- Admits filter and IFM chunk write beats from the upstream loader into two ping-pong banks per operand.
- Fires chunk_start_o when both operands have a full bank, holds the bank selects until chunk_end_i, then frees the banks.
- Counts chunks to a programmed total. Sparsemap and nonzero data bypass this block; only valid/count/select/start signals are generated here.

Parameters:
- BUS_SIZE, 32, nonzero elements per write beat
- MEM_SIZE, 128, elements per data chunk bank
- PREFIX_SUM_SIZE, 8, sparsemap bits consumed per priority-encoder pass
- WR_DAT_CYC_NUM, MEM_SIZE/BUS_SIZE, maximum beats per chunk
- RD_SPARSEMAP_NUM, MEM_SIZE/PREFIX_SUM_SIZE, maximum sparsemap words per chunk
- CHUNK_CNT_W, 16, width of the chunk counter

Ports:
- clk_i in 1: clock; all logic on rising edge.
- rst_i in 1: reset, synchronous, active-low (0 = reset).
- start_i in 1: pulse; latches cfg_*, begins a layer. Ignored while busy_o.
- cfg_chunk_num_i in CHUNK_CNT_W: chunks in layer; 0 = immediate done.
- cfg_beats_i in $clog2(WR_DAT_CYC_NUM)+1: beats per chunk, 1..WR_DAT_CYC_NUM.
- cfg_sparsemap_num_i in $clog2(RD_SPARSEMAP_NUM): last sparsemap index, passed through to the selector.
- ifm_beat_valid_i in 1 / ifm_beat_ready_o out 1: IFM beat handshake.
- filter_beat_valid_i in 1 / filter_beat_ready_o out 1: filter beat handshake.
- ifm_wr_valid_o, filter_wr_valid_o out 1: write strobes = valid & ready.
- ifm_wr_count_o, filter_wr_count_o out $clog2(WR_DAT_CYC_NUM): beat index in bank.
- ifm_wr_sel_o, filter_wr_sel_o out 1: bank being written.
- ifm_rd_sel_o, filter_rd_sel_o out 1: bank being read.
- chunk_start_o out 1: one-cycle pulse.
- run_valid_o out 1: high in START and RUN.
- rd_sparsemap_num_o out $clog2(RD_SPARSEMAP_NUM): latched cfg.
- chunk_end_i in 1: level from the selector.
- busy_o out 1; done_o out 1 (one-cycle pulse).

Behaviour:
- Reset values: all outputs 0; bank full flags 00; write pointers and read pointers 0; beat counters 0; chunk counters 0; FSM IDLE.
- Writer, per operand, independent:
  - ready_o = busy_o & !full[wr_ptr] & (chunks_loaded < chunk_num).
  - Each accepted beat increments the beat count. On beat cfg_beats-1: set full[wr_ptr], toggle wr_ptr, reset count, increment chunks_loaded.
  - wr_sel_o = wr_ptr; wr_count_o = beat count.
- Reader FSM:
  - IDLE: start_i -> LOAD; done if chunk_num=0.
  - LOAD: when ifm full[rd_ptr] & filter full[rd_ptr] -> START.
  - START: one cycle; chunk_start_o=1; -> RUN.
  - RUN: sample chunk_end_i only from the cycle after START. On chunk_end_i=1: clear full[rd_ptr], toggle rd_ptr, increment chunks_done. If chunks_done+1 == chunk_num -> DONE, else -> LOAD.
  - DONE: done_o=1 for one cycle, busy_o drops -> IDLE.
- rd_sel_o holds rd_ptr through START and RUN.
- Same-cycle free and write:
  - A freed bank is writable from the next cycle; ready is not combinationally bypassed.
  - A writer completing a bank in the same cycle the reader frees the other bank: both updates apply.
- Latency: last beat of the second operand to chunk_start_o = 2 cycles (full flag registered, LOAD -> START).
- Reset mid-layer aborts everything: flags cleared, no done_o.
- start_i while busy: ignored.
- Counters compare equality only; no wrap within a layer.

Optional Feature:
- CHUNK_SCHED_PERF_EN defined: adds outputs stall_cyc_o [31:0] and run_cyc_o [31:0].
  - stall_cyc_o counts cycles in LOAD; run_cyc_o counts cycles in RUN.
  - Both cleared on start_i, saturate at all-ones, hold after done.
- Undefined: ports and counters absent.

Decomposition:
- Package chunk_sched_pkg: state enum (IDLE, LOAD, START, RUN, DONE), width localparams derived from BUS_SIZE/MEM_SIZE/PREFIX_SUM_SIZE.
- Sub-module chunk_bank_ctrl: one operand's ping-pong writer plus full flags; instantiated twice (IFM, filter).

Test Plan:
- cfg_chunk_num=3, cfg_beats=4, both streams always valid -> 3 chunk_start_o pulses, rd_sel 0,1,0; done_o after the third chunk_end_i.
- Filter valid held low after chunk 1 -> stays in LOAD, stall counter increments; resumes 2 cycles after the filter's last beat.
- Both banks full, chunk_end_i delayed 20 cycles -> both ready_o low for the whole interval; high the cycle after chunk_end_i.
- chunk_end_i held high continuously (selector idle) -> exactly one chunk retires per START/RUN pair; no double free.
- cfg_chunk_num=0, start_i -> done_o next cycle, no write strobes.
- rst_i=0 mid-RUN of chunk 2 -> all outputs 0 next cycle; a new start_i runs a clean layer.
